// File: rtl/step_controller.sv
// Debounced single-step / auto-run step generator for a CPU step-enable input.
// Define STEP_CTRL_AUTORUN_EN to build in the free-running auto-step divider.
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_DIV        = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        btn_n,
  input  logic        run_sw,
  output logic        step_pulse,
  output logic        btn_stable,
  output logic [15:0] step_count
);

  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) > 16) ? $clog2(DEBOUNCE_CYCLES) : 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [1:0]       btn_sync_q;
  logic             btn_sync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_stable_q;
  logic             press_done_c;
  logic             auto_mode_c;
  logic             auto_fire_c;
  logic             step_pulse_q;
  logic             step_pulse_d;
  logic [15:0]      step_count_q;
  logic [15:0]      step_count_d;

  // Two-flop synchroniser; the button is inverted so 1 means pressed.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      btn_sync_q <= 2'b00;
    end else begin
      btn_sync_q <= {btn_sync_q[0], ~btn_n};
    end
  end

  assign btn_sync = btn_sync_q[1];

`ifdef STEP_CTRL_AUTORUN_EN
  localparam int unsigned DIV_W = $clog2(AUTO_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

  logic [1:0]       run_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             div_wrap_c;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      run_sync_q <= 2'b00;
      div_q      <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], run_sw};
      div_q      <= div_d;
    end
  end

  // Divider free-runs only in auto mode and parks at zero otherwise.
  always_comb begin
    div_wrap_c = run_sync_q[1] && (div_q == DIV_LAST);
    div_d      = '0;
    if (run_sync_q[1] && !div_wrap_c) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign auto_mode_c = run_sync_q[1];
  assign auto_fire_c = div_wrap_c;
`else
  logic unused_run_sw;

  assign unused_run_sw = run_sw;
  assign auto_mode_c   = 1'b0;
  assign auto_fire_c   = 1'b0;
`endif

  // Debounce FSM: a level is accepted only after DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      btn_stable_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_sync) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= HELD;
            btn_stable_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_sync) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= IDLE;
            btn_stable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign press_done_c = (state_q == PRESS_WAIT) && btn_sync && (cnt_q == CNT_LAST);

  // Auto mode owns the pulse source; accepted presses only step in manual mode.
  always_comb begin
    step_pulse_d = 1'b0;
    if (auto_mode_c) begin
      step_pulse_d = auto_fire_c && !step_pulse_q;
    end else begin
      step_pulse_d = press_done_c && !step_pulse_q;
    end
    step_count_d = step_count_q + {15'd0, step_pulse_q};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      step_pulse_q <= 1'b0;
      step_count_q <= 16'd0;
    end else begin
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign btn_stable = btn_stable_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with DEBOUNCE_CYCLES=4, AUTO_DIV=8.
module tb_step_controller;

  localparam int unsigned DEB  = 4;
  localparam int unsigned ADIV = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        btn_n;
  logic        run_sw;
  logic        step_pulse;
  logic        btn_stable;
  logic [15:0] step_count;

  int   total = 0;
  int   bad = 0;
  int   pulses_seen = 0;
  int   consec = 0;
  int   p0 = 0;
  logic prev_pulse = 1'b0;

  step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_DIV       (ADIV)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .btn_n     (btn_n),
    .run_sw    (run_sw),
    .step_pulse(step_pulse),
    .btn_stable(btn_stable),
    .step_count(step_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (step_pulse === 1'b1) begin
      pulses_seen++;
      if (prev_pulse === 1'b1) consec++;
    end
    prev_pulse = step_pulse;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_n  = 1'b1;
    run_sw = 1'b0;
    tick(2);
    chk("rst_pulse", 32'(step_pulse), 0);
    chk("rst_stable", 32'(btn_stable), 0);
    chk("rst_count", 32'(step_count), 0);
    reset = 1'b0;
    tick(2);

    // Long press: one pulse after edge 7, stable until release debounces.
    btn_n = 1'b0;
    tick(6);
    chk("press_pulse_e6", 32'(step_pulse), 0);
    chk("press_stable_e6", 32'(btn_stable), 0);
    tick(1);
    chk("press_pulse_e7", 32'(step_pulse), 1);
    chk("press_stable_e7", 32'(btn_stable), 1);
    chk("press_count_e7", 32'(step_count), 0);
    tick(1);
    chk("press_pulse_e8", 32'(step_pulse), 0);
    chk("press_count_e8", 32'(step_count), 1);
    tick(12);
    chk("press_single", 32'(pulses_seen), 1);
    btn_n = 1'b1;
    tick(6);
    chk("release_stable_e6", 32'(btn_stable), 1);
    tick(1);
    chk("release_stable_e7", 32'(btn_stable), 0);
    tick(5);

    // Glitches of 3 and 4 cycles are rejected.
    p0 = pulses_seen;
    btn_n = 1'b0;
    tick(3);
    btn_n = 1'b1;
    tick(1);
    chk("glitch3_stable", 32'(btn_stable), 0);
    tick(11);
    chk("glitch3_pulses", 32'(pulses_seen - p0), 0);
    chk("glitch3_count", 32'(step_count), 1);
    btn_n = 1'b0;
    tick(4);
    btn_n = 1'b1;
    tick(12);
    chk("glitch4_pulses", 32'(pulses_seen - p0), 0);
    chk("glitch4_stable", 32'(btn_stable), 0);

    // Five low samples is the shortest accepted press.
    btn_n = 1'b0;
    tick(5);
    btn_n = 1'b1;
    tick(1);
    chk("min_press_e6", 32'(step_pulse), 0);
    tick(1);
    chk("min_press_e7", 32'(step_pulse), 1);
    tick(12);
    chk("min_press_count", 32'(step_count), 2);
    chk("min_press_stable", 32'(btn_stable), 0);

    // Short release bounce while held gives no second step.
    p0 = pulses_seen;
    btn_n = 1'b0;
    tick(10);
    chk("bounce_first", 32'(step_count), 3);
    btn_n = 1'b1;
    tick(2);
    btn_n = 1'b0;
    tick(12);
    chk("bounce_pulses", 32'(pulses_seen - p0), 1);
    chk("bounce_stable", 32'(btn_stable), 1);
    chk("bounce_count", 32'(step_count), 3);
    btn_n = 1'b1;
    tick(12);
    chk("bounce_released", 32'(btn_stable), 0);

    // Counter wrap from 16'hFFFF.
    force dut.step_count_q = 16'hFFFF;
    tick(1);
    release dut.step_count_q;
    tick(1);
    chk("wrap_preload", 32'(step_count), 32'h0000_FFFF);
    btn_n = 1'b0;
    tick(7);
    chk("wrap_pulse", 32'(step_pulse), 1);
    tick(1);
    chk("wrap_count", 32'(step_count), 0);
    btn_n = 1'b1;
    tick(12);

`ifdef STEP_CTRL_AUTORUN_EN
    // Auto-run: pulse after edges 10, 18, 26, 34; a press during it adds none.
    run_sw = 1'b1;
    p0 = pulses_seen;
    tick(9);
    chk("auto_e9", 32'(step_pulse), 0);
    tick(1);
    chk("auto_e10", 32'(step_pulse), 1);
    tick(7);
    chk("auto_e17", 32'(step_pulse), 0);
    tick(1);
    chk("auto_e18", 32'(step_pulse), 1);
    btn_n = 1'b0;
    tick(20);
    run_sw = 1'b0;
    tick(10);
    chk("auto_pulses", 32'(pulses_seen - p0), 4);
    chk("auto_stable", 32'(btn_stable), 1);
    chk("auto_count", 32'(step_count), 4);
    btn_n = 1'b1;
    tick(12);
`else
    // Without auto-run the switch is ignored and presses still step.
    run_sw = 1'b1;
    p0 = pulses_seen;
    tick(40);
    chk("norun_pulses", 32'(pulses_seen - p0), 0);
    btn_n = 1'b0;
    tick(6);
    chk("norun_press_e6", 32'(step_pulse), 0);
    tick(1);
    chk("norun_press_e7", 32'(step_pulse), 1);
    tick(1);
    chk("norun_count", 32'(step_count), 1);
    btn_n  = 1'b1;
    run_sw = 1'b0;
    tick(12);
`endif

    // Reset in PRESS_WAIT, then in the pulse cycle, with the button held.
    btn_n = 1'b0;
    tick(4);
    reset = 1'b1;
    #1;
    chk("rst_pw_stable", 32'(btn_stable), 0);
    chk("rst_pw_count", 32'(step_count), 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("rst_pw_e6", 32'(step_pulse), 0);
    tick(1);
    chk("rst_pw_e7", 32'(step_pulse), 1);
    reset = 1'b1;
    #1;
    chk("rst_pulse_abort", 32'(step_pulse), 0);
    chk("rst_pulse_count", 32'(step_count), 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("rst_again_e6", 32'(step_pulse), 0);
    tick(1);
    chk("rst_again_e7", 32'(step_pulse), 1);
    tick(1);
    chk("rst_again_count", 32'(step_count), 1);
    chk("rst_again_stable", 32'(btn_stable), 1);
    btn_n = 1'b1;
    tick(12);

    chk("no_back_to_back", 32'(consec), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-sample count for press/release acceptance (10 ms at 50 MHz); legal range >=2.
REQ-002 Parameter AUTO_DIV, default 25000000, CLOCK_50 cycles between auto-run steps; legal range >=2.
REQ-003 CLOCK_50  input  1  single clock for all state; rising edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_n  input  1  raw, unsynchronised, active-low push button.
REQ-006 run_sw  input  1  1 = auto-run mode, 0 = manual single-step mode.
REQ-007 step_pulse  output  1  registered one-cycle step enable for the CPU step input.
REQ-008 btn_stable  output  1  debounced button level, 1 = pressed.
REQ-009 step_count  output  16  count of step_pulse assertions since reset.

Function
REQ-010 Synchroniser: btn_sync SHALL be ~btn_n after two flops; no other logic SHALL use btn_n directly.
REQ-011 Debounce FSM states SHALL be IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; 16-bit-or-wider counter cnt.
REQ-012 IDLE: btn_sync=1 -> PRESS_WAIT, cnt<=0; otherwise stay.
REQ-013 PRESS_WAIT: btn_sync=0 -> IDLE; btn_sync=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD; else cnt+1.
REQ-014 HELD: btn_sync=0 -> RELEASE_WAIT, cnt<=0; otherwise stay.
REQ-015 RELEASE_WAIT: btn_sync=1 -> HELD without pulse; btn_sync=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-016 btn_stable SHALL be 1 exactly when state is HELD or RELEASE_WAIT.
REQ-017 Manual step: when run_sw=0, PRESS_WAIT->HELD transition SHALL set step_pulse=1 for exactly the following cycle.
REQ-018 Latency: step_pulse SHALL go high after the (DEBOUNCE_CYCLES+3)th rising edge counting the first edge that samples btn_n=0, given btn_n held low throughout.
REQ-019 One press, however long held, SHALL yield exactly one step_pulse; glitches shorter than DEBOUNCE_CYCLES SHALL yield none.
REQ-020 step_pulse SHALL never be high on two consecutive cycles.
REQ-021 step_count SHALL increment by 1 in the cycle after each step_pulse assertion, wrapping 16'hFFFF -> 16'h0000.
REQ-022 While run_sw=1, the debounce FSM SHALL keep running but its transitions SHALL NOT generate step_pulse.

Reset
REQ-023 Asserting reset SHALL immediately force: synchroniser flops 0, state IDLE, cnt 0, auto divider 0, step_pulse 0, btn_stable 0, step_count 0.
REQ-024 Reset mid-debounce or mid-pulse SHALL abort without a pending pulse; after release, a still-held button SHALL be treated as a new press (full REQ-018 latency).

Configuration
REQ-025 Macro STEP_CTRL_AUTORUN_EN SHALL compile in the auto-run divider.
REQ-026 With STEP_CTRL_AUTORUN_EN defined: while run_sw=1, divider counts 0..AUTO_DIV-1; on reaching AUTO_DIV-1 it wraps to 0 and step_pulse=1 next cycle; run_sw=0 holds divider at 0; first auto pulse follows AUTO_DIV cycles after run_sw rises (synchronised run_sw internally, two flops).
REQ-027 Without STEP_CTRL_AUTORUN_EN: no divider logic; run_sw SHALL be ignored and behaviour SHALL be manual mode per REQ-017 at all times.

Verification (DEBOUNCE_CYCLES=4, AUTO_DIV=8)
REQ-028 run_sw=0, btn_n low for 20 cycles -> single step_pulse after 7th edge, btn_stable=1, step_count=1.
REQ-029 btn_n low 3 cycles then high -> no step_pulse, btn_stable stays 0, step_count=0.
REQ-030 Press, release 2 cycles, press again (bounce inside RELEASE_WAIT) -> no second pulse, step_count=1.
REQ-031 Preload step_count=16'hFFFF via 65535 pulses (or force), one more press -> step_count=16'h0000.
REQ-032 STEP_CTRL_AUTORUN_EN defined, run_sw=1 for 40 cycles -> pulses every 8 cycles, button presses add none; undefined -> no pulses.
REQ-033 reset asserted during PRESS_WAIT with btn held, deasserted -> pulse 7 edges after release of reset, never earlier.
